// File: rtl/boid_fb_pkg.sv
// Shared constants and types for the boid framebuffer write scheduler.
// Optional 2x2 block plotting is selected with the BOID_BLOCK2X2_EN macro.
package boid_fb_pkg;
  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int ADDR_W = 20;

  typedef logic [ADDR_W-1:0] pix_addr_t;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    ERASE,
    FETCH,
    PLOT,
    DONE
  } fb_state_e;
endpackage

// File: rtl/boid_fb_addr_calc.sv
// Maps a pixel coordinate to its linear framebuffer address and an in-bounds flag.
// Purely combinational; shared by the scheduler and the VGA-side address logic.
module boid_fb_addr_calc
  import boid_fb_pkg::*;
#(
  parameter int FB_W   = boid_fb_pkg::FB_W,
  parameter int FB_H   = boid_fb_pkg::FB_H,
  parameter int ADDR_W = boid_fb_pkg::ADDR_W,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
) (
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_bounds_o
);
  // Constant multiply by FB_W unrolled into one shifted copy of y per set bit.
  // NOTE: blocking assignments let addr_o accumulate within one evaluation, and
  // assigning it first on every pass keeps the block free of inferred latches.
  always_comb begin
    addr_o = ADDR_W'(x_i);
    for (int b = 0; b < 31; b++) begin
      if (FB_W[b]) addr_o = addr_o + (ADDR_W'(y_i) << b);
    end
  end

  assign in_bounds_o = (32'(x_i) < 32'(FB_W)) && (32'(y_i) < 32'(FB_H));
endmodule

// File: rtl/boid_fb_scheduler.sv
// Sequences clear/erase/plot writes into the 1-bit boid framebuffer, yielding the port to VGA reads.
// Define BOID_BLOCK2X2_EN to plot and erase each boid as a clipped 2x2 block.
module boid_fb_scheduler
  import boid_fb_pkg::*;
#(
  parameter int NUM_BOIDS = 32,
  parameter int FB_W      = boid_fb_pkg::FB_W,
  parameter int FB_H      = boid_fb_pkg::FB_H,
  parameter int ADDR_W    = boid_fb_pkg::ADDR_W,
  parameter int X_W       = 10,
  parameter int Y_W       = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_sync,
  input  logic                         vga_rd_req,
  input  logic [ADDR_W-1:0]            vga_rd_addr,
  output logic [$clog2(NUM_BOIDS)-1:0] boid_idx,
  input  logic [X_W-1:0]               boid_x,
  input  logic [Y_W-1:0]               boid_y,
  output logic [ADDR_W-1:0]            fb_addr,
  output logic                         fb_we,
  output logic                         fb_wdata,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);
  localparam int IDX_W   = $clog2(NUM_BOIDS);
  localparam int NUM_PIX = FB_W * FB_H;

  fb_state_e            state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [ADDR_W-1:0]    clr_q;
  logic                 sync_q, busy_q, frame_done_q, overrun_q;
  logic [NUM_BOIDS-1:0] shadow_valid_q;
  logic [ADDR_W-1:0]    shadow_addr_q [NUM_BOIDS];

  logic [ADDR_W-1:0] calc_addr, blk_off, fsm_addr;
  logic calc_in_bounds, sync_rise, last_boid, last_sub;
  logic erase_skip, plot_skip, fsm_we, fsm_wdata, step_ok;

  boid_fb_addr_calc #(
    .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .X_W(X_W), .Y_W(Y_W)
  ) u_addr_calc (
    .x_i        (boid_x),
    .y_i        (boid_y),
    .addr_o     (calc_addr),
    .in_bounds_o(calc_in_bounds)
  );

  assign sync_rise = frame_sync & ~sync_q;
  assign last_boid = (idx_q == IDX_W'(NUM_BOIDS - 1));

`ifdef BOID_BLOCK2X2_EN
  logic [1:0] sub_q;
  logic [1:0] calc_clip;                      // {row clipped, column clipped}
  logic [1:0] shadow_clip_q [NUM_BOIDS];

  assign calc_clip  = {(32'(boid_y) + 1) >= 32'(FB_H), (32'(boid_x) + 1) >= 32'(FB_W)};
  assign last_sub   = &sub_q;
  assign blk_off    = (sub_q[0] ? ADDR_W'(1) : '0) + (sub_q[1] ? ADDR_W'(FB_W) : '0);
  assign erase_skip = |(sub_q & shadow_clip_q[idx_q]);
  assign plot_skip  = |(sub_q & calc_clip);
`else
  assign last_sub   = 1'b1;
  assign blk_off    = '0;
  assign erase_skip = 1'b0;
  assign plot_skip  = 1'b0;
`endif

  always_comb begin
    fsm_addr  = clr_q;
    fsm_we    = 1'b0;
    fsm_wdata = 1'b0;
    case (state_q)
      CLEAR: fsm_we = busy_q;
      ERASE: begin
        fsm_addr = shadow_addr_q[idx_q] + blk_off;
        fsm_we   = shadow_valid_q[idx_q] & ~erase_skip;
      end
      PLOT: begin
        fsm_addr  = calc_addr + blk_off;
        fsm_we    = calc_in_bounds & ~plot_skip;
        fsm_wdata = 1'b1;
      end
      default: ;
    endcase
  end

  // A pending write completes only on a cycle the VGA reader leaves free.
  assign step_ok    = ~fsm_we | ~vga_rd_req;
  assign fb_addr    = vga_rd_req ? vga_rd_addr : fsm_addr;
  assign fb_we      = fsm_we & ~vga_rd_req;
  assign fb_wdata   = fsm_wdata & ~vga_rd_req;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign boid_idx   = idx_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= CLEAR;
      idx_q          <= '0;
      clr_q          <= '0;
      sync_q         <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
      shadow_valid_q <= '0;
`ifdef BOID_BLOCK2X2_EN
      sub_q          <= '0;
`endif
    end else begin
      sync_q       <= frame_sync;
      frame_done_q <= 1'b0;
      overrun_q    <= sync_rise && (state_q != IDLE);
      case (state_q)
        CLEAR: begin
          if (!busy_q) begin
            busy_q <= 1'b1;
          end else if (step_ok) begin
            if (clr_q == ADDR_W'(NUM_PIX - 1)) begin
              clr_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              clr_q <= clr_q + 1'b1;
            end
          end
        end
        IDLE: begin
          if (sync_rise) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ERASE;
          end
        end
        ERASE: begin
          if (!shadow_valid_q[idx_q] || (step_ok && last_sub)) begin
            idx_q <= idx_q + 1'b1;
            if (last_boid) state_q <= FETCH;
          end
        end
        FETCH: state_q <= PLOT;
        PLOT: begin
          shadow_valid_q[idx_q] <= calc_in_bounds;
          if (!calc_in_bounds || (step_ok && last_sub)) begin
            idx_q   <= idx_q + 1'b1;
            state_q <= last_boid ? DONE : FETCH;
          end
        end
        DONE: begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= CLEAR;
      endcase
`ifdef BOID_BLOCK2X2_EN
      if (step_ok && ((state_q == ERASE && shadow_valid_q[idx_q]) ||
                      (state_q == PLOT && calc_in_bounds))) begin
        sub_q <= sub_q + 1'b1;
      end
`endif
    end
  end

  // NOTE: shadow addresses carry no reset; shadow_valid_q alone says whether an entry is live.
  always_ff @(posedge clk) begin
    if (state_q == PLOT && calc_in_bounds) begin
      shadow_addr_q[idx_q] <= calc_addr;
`ifdef BOID_BLOCK2X2_EN
      shadow_clip_q[idx_q] <= calc_clip;
`endif
    end
  end
endmodule

// File: tb/tb_boid_fb_scheduler.sv
// Directed, table-driven bench for boid_fb_scheduler with four boids.
module tb_boid_fb_scheduler;
  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset, frame_sync, vga_rd_req;
  logic [19:0] vga_rd_addr;
  logic [1:0]  boid_idx;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic [19:0] fb_addr;
  logic        fb_we, fb_wdata, busy, frame_done, overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int arb_err = 0;
  bit log_en  = 1'b0;
  int wlog_a[$];
  int wlog_d[$];
  int pos_x[NB];
  int pos_y[NB];

  typedef struct {
    int px[NB];
    int py[NB];
    bit stall;
    bit dbl;
    int lat;
    int ovr;
    int n_er;
    int n_wr;
    int wa[8];
  } vec_t;

`ifdef BOID_BLOCK2X2_EN
  localparam int NV = 2;
`else
  localparam int NV = 6;
`endif
  vec_t vecs[NV];

  always #5 clk = ~clk;

  boid_fb_scheduler #(.NUM_BOIDS(NB)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_sync (frame_sync),
    .vga_rd_req (vga_rd_req),
    .vga_rd_addr(vga_rd_addr),
    .boid_idx   (boid_idx),
    .boid_x     (boid_x),
    .boid_y     (boid_y),
    .fb_addr    (fb_addr),
    .fb_we      (fb_we),
    .fb_wdata   (fb_wdata),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  // Position store: registered read, one cycle after boid_idx.
  always @(posedge clk) begin
    boid_x <= 10'(pos_x[boid_idx]);
    boid_y <= 9'(pos_y[boid_idx]);
  end

  always @(negedge clk) begin
    if (log_en && fb_we) begin
      wlog_a.push_back(int'(fb_addr));
      wlog_d.push_back(int'(fb_wdata));
    end
    if (vga_rd_req && (fb_we || fb_addr != vga_rd_addr)) arb_err++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered just after a posedge; returns on a negedge.
  task automatic run_vec(input int n, input vec_t v);
    int  lat, ovr, got;
    bit  done;
    for (int b = 0; b < NB; b++) begin
      pos_x[b] = v.px[b];
      pos_y[b] = v.py[b];
    end
    wlog_a.delete();
    wlog_d.delete();
    log_en     = 1'b1;
    lat        = 0;
    ovr        = 0;
    done       = 1'b0;
    frame_sync = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      frame_sync  = (k < 3) || (v.dbl && k >= 5 && k <= 7);
      vga_rd_req  = v.stall && (k % 2 == 0) && k >= 6 && k <= 14;
      vga_rd_addr = 20'($urandom_range(0, 76799));
      @(negedge clk);
      if (overrun) ovr++;
      if (frame_done) begin
        lat  = k;
        done = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    frame_sync = 1'b0;
    vga_rd_req = 1'b0;
    @(negedge clk);
    log_en = 1'b0;
    check($sformatf("v%0d_latency", n), lat, v.lat);
    check($sformatf("v%0d_overrun", n), ovr, v.ovr);
    check($sformatf("v%0d_done_pulse", n), int'(frame_done), 0);
    check($sformatf("v%0d_idle_busy", n), int'(busy), 0);
    got = wlog_a.size();
    check($sformatf("v%0d_wr_count", n), got, v.n_wr);
    for (int i = 0; i < v.n_wr; i++) begin
      if (i < got) begin
        check($sformatf("v%0d_wr%0d_addr", n, i), wlog_a[i], v.wa[i]);
        check($sformatf("v%0d_wr%0d_data", n, i), wlog_d[i], (i < v.n_er) ? 0 : 1);
      end
    end
  endtask

  initial begin
    int clr_err, waited;

`ifdef BOID_BLOCK2X2_EN
    vecs[0] = '{px:'{319, 400, 400, 320}, py:'{10, 10, 10, 0}, stall:1'b0, dbl:1'b0,
                lat:17, ovr:0, n_er:0, n_wr:2, wa:'{3519, 3839, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{px:'{319, 0, 400, 320}, py:'{10, 0, 10, 0}, stall:1'b0, dbl:1'b0,
                lat:23, ovr:0, n_er:2, n_wr:8, wa:'{3519, 3839, 3519, 3839, 0, 1, 320, 321}};
`else
    vecs[0] = '{px:'{0, 319, 10, 400}, py:'{0, 239, 5, 10}, stall:1'b0, dbl:1'b0,
                lat:14, ovr:0, n_er:0, n_wr:3, wa:'{0, 76799, 1610, 0, 0, 0, 0, 0}};
    vecs[1] = '{px:'{0, 319, 11, 400}, py:'{0, 239, 5, 10}, stall:1'b0, dbl:1'b0,
                lat:14, ovr:0, n_er:3, n_wr:6, wa:'{0, 76799, 1610, 0, 76799, 1611, 0, 0}};
    vecs[2] = '{px:'{0, 319, 11, 400}, py:'{0, 239, 5, 10}, stall:1'b1, dbl:1'b0,
                lat:15, ovr:0, n_er:3, n_wr:6, wa:'{0, 76799, 1611, 0, 76799, 1611, 0, 0}};
    vecs[3] = '{px:'{0, 319, 11, 5}, py:'{0, 239, 5, 0}, stall:1'b0, dbl:1'b1,
                lat:14, ovr:1, n_er:3, n_wr:7, wa:'{0, 76799, 1611, 0, 76799, 1611, 5, 0}};
    vecs[4] = '{px:'{0, 319, 11, 320}, py:'{0, 239, 5, 0}, stall:1'b0, dbl:1'b0,
                lat:14, ovr:0, n_er:4, n_wr:7, wa:'{0, 76799, 1611, 5, 0, 76799, 1611, 0}};
    vecs[5] = '{px:'{0, 319, 11, 320}, py:'{240, 239, 5, 0}, stall:1'b0, dbl:1'b0,
                lat:14, ovr:0, n_er:3, n_wr:5, wa:'{0, 76799, 1611, 76799, 1611, 0, 0, 0}};
`endif

    reset       = 1'b1;
    frame_sync  = 1'b0;
    vga_rd_req  = 1'b0;
    vga_rd_addr = '0;
    for (int b = 0; b < NB; b++) begin
      pos_x[b] = 0;
      pos_y[b] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_wdata", int'(fb_wdata), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_boid_idx", int'(boid_idx), 0);

    // Post-reset clear: 76800 back-to-back zero writes, then idle.
    @(posedge clk); #1;
    reset   = 1'b0;
    clr_err = 0;
    waited  = 0;
    @(negedge clk);
    while (!fb_we && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    for (int k = 0; k < 76800; k++) begin
      if (!(fb_we === 1'b1 && fb_wdata === 1'b0 && int'(fb_addr) == k)) clr_err++;
      @(negedge clk);
    end
    check("clear_sequence_errors", clr_err, 0);
    check("clear_end_busy", int'(busy), 0);
    check("clear_end_fb_we", int'(fb_we), 0);

    for (int n = 0; n < NV; n++) begin
      @(posedge clk); #1;
      run_vec(n, vecs[n]);
    end
    check("vga_priority_errors", arb_err, 0);

    // Reset mid-frame aborts at once and restarts the clear from address 0.
    @(posedge clk); #1;
    frame_sync = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset      = 1'b1;
    frame_sync = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_fb_we", int'(fb_we), 0);
    check("midrst_boid_idx", int'(boid_idx), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reclear_fb_we", int'(fb_we), 1);
    check("reclear_fb_addr", int'(fb_addr), 0);
    check("reclear_busy", int'(busy), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
